// File: rtl/riscv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// riscv_ctrl_pkg
// Shared encodings for the multi-cycle RV32I control unit: opcodes, FSM
// states, ALU operations, immediate formats and datapath mux selects, plus
// the branch-condition helper used by the BRANCH state.
// ---------------------------------------------------------------------------
package riscv_ctrl_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_OP     = 7'b0110011,
        OP_OP_IMM = 7'b0010011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111
    } opcode_e;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13,
        S_ERROR    = 4'd14
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_src_e;

    // What the FSM asks of the ALU decoder in a given state.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC_A_PC    = 2'b00,
        SRC_A_OLDPC = 2'b01,
        SRC_A_RS1   = 2'b10,
        SRC_A_ZERO  = 2'b11
    } src_a_e;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'b00,
        SRC_B_IMM  = 2'b01,
        SRC_B_FOUR = 2'b10
    } src_b_e;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_MEMDATA   = 2'b01,
        RES_ALURESULT = 2'b10
    } result_src_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Reserved branch funct3 values (010, 011) never take the branch.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic       zero,
                                          input logic       lt,
                                          input logic       ltu);
        case (funct3)
            F3_BEQ:  return zero;
            F3_BNE:  return !zero;
            F3_BLT:  return lt;
            F3_BGE:  return !lt;
            F3_BLTU: return ltu;
            F3_BGEU: return !ltu;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Combinational ALU-control decode.
//   alu_op_i    : request from the FSM (force ADD, force SUB, or use funct)
//   funct3_i    : instruction funct3
//   funct7b5_i  : instruction bit 30
//   is_rtype_i  : 1 for register-register ALU instructions
//   alu_ctrl_o  : ALU operation
// ---------------------------------------------------------------------------
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_op_e    alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       is_rtype_i,
    output alu_ctrl_e  alu_ctrl_o
);

    // NOTE: every output of a combinational block gets a default before the
    // case, so no path can leave it unassigned and infer a latch.
    always_comb begin
        alu_ctrl_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_SUB: alu_ctrl_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // Bit 30 of an I-type is immediate data, so only an
                    // R-type may select SUB.
                    3'b000: alu_ctrl_o = (is_rtype_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_ctrl_o = ALU_SLL;
                    // The 3-bit ALU code has no SLTU/SRA slots; they share
                    // SLT/SRL.
                    3'b010,
                    3'b011: alu_ctrl_o = ALU_SLT;
                    3'b100: alu_ctrl_o = ALU_XOR;
                    3'b101: alu_ctrl_o = ALU_SRL;
                    3'b110: alu_ctrl_o = ALU_OR;
                    3'b111: alu_ctrl_o = ALU_AND;
                    default: alu_ctrl_o = ALU_ADD;
                endcase
            end
            default: alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_unit_fsm.sv
// ---------------------------------------------------------------------------
// control_unit_fsm
// Multi-cycle RV32I control unit with memory-wait timeout and illegal-opcode
// trap.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   instr_i                    : instruction register contents
//   mem_ready_i                : memory completes the current access
//   zero_i, lt_i, ltu_i        : ALU flags for branch resolution
//   pc_write_o, ir_write_o,
//   reg_write_o, mem_read_o,
//   mem_write_o                : datapath enables (forced 0 during reset)
//   adr_src_o                  : memory address select (0 = PC, 1 = ALUOut)
//   alu_src_a_o, alu_src_b_o,
//   result_src_o               : datapath mux selects
//   imm_src_o, alu_ctrl_o      : immediate format, ALU operation
//   illegal_o, timeout_o       : sticky error flags
//   state_o                    : current state, for debug
// ---------------------------------------------------------------------------
module control_unit_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter bit          TRAP_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_i,
    input  logic        mem_ready_i,
    input  logic        zero_i,
    input  logic        lt_i,
    input  logic        ltu_i,
    output logic        pc_write_o,
    output logic        ir_write_o,
    output logic        reg_write_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        adr_src_o,
    output logic [1:0]  alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [1:0]  result_src_o,
    output logic [2:0]  imm_src_o,
    output logic [2:0]  alu_ctrl_o,
    output logic        illegal_o,
    output logic        timeout_o,
    output logic [3:0]  state_o
);

    // The counter never holds MEM_TIMEOUT itself: the cycle that would reach
    // it leaves for ERROR instead.
    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       unused_instr;

    assign opcode       = instr_i[6:0];
    assign funct3       = instr_i[14:12];
    assign funct7b5     = instr_i[30];
    assign unused_instr = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

    logic mem_wait_state;
    logic wait_expired;

    assign mem_wait_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                            (state_q == S_MEMWRITE);
    assign wait_expired   = (wait_q == CNT_W'(MEM_TIMEOUT - 1));

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        wait_d    = '0;

        // A ready in the expiring cycle still completes the access.
        if (mem_wait_state && !mem_ready_i) begin
            if (wait_expired) begin
                state_d   = S_ERROR;
                timeout_d = 1'b1;
            end else begin
                wait_d = wait_q + CNT_W'(1);
            end
        end

        case (state_q)
            S_FETCH:    if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD,
                    OP_STORE:  state_d = S_MEMADR;
                    OP_OP:     state_d = S_EXECR;
                    OP_OP_IMM: state_d = S_EXECI;
                    OP_BRANCH: state_d = S_BRANCH;
                    OP_JAL:    state_d = S_JAL;
                    OP_JALR:   state_d = S_JALR;
                    OP_LUI:    state_d = S_LUI;
                    OP_AUIPC:  state_d = S_AUIPC;
                    default: begin
                        if (TRAP_ILLEGAL) begin
                            state_d   = S_ERROR;
                            illegal_d = 1'b1;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready_i) state_d = S_MEMWB;
            S_MEMWRITE: if (mem_ready_i) state_d = S_FETCH;
            S_MEMWB:    state_d = S_FETCH;
            S_EXECR,
            S_EXECI,
            S_LUI,
            S_AUIPC,
            S_JAL,
            S_JALR:     state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_ERROR:    state_d = S_ERROR;
            default:    state_d = S_ERROR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    logic        pc_write, ir_write, reg_write, mem_read, mem_write;
    alu_op_e     alu_op;
    src_a_e      src_a;
    src_b_e      src_b;
    result_src_e result_src;

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        adr_src_o  = 1'b0;
        src_a      = SRC_A_PC;
        src_b      = SRC_B_RS2;
        result_src = RES_ALUOUT;
        alu_op     = ALUOP_ADD;

        case (state_q)
            S_FETCH: begin
                mem_read   = 1'b1;
                ir_write   = mem_ready_i;
                pc_write   = mem_ready_i;
                src_a      = SRC_A_PC;
                src_b      = SRC_B_FOUR;
                result_src = RES_ALURESULT;
            end
            // Precompute the branch/JAL target (old PC + imm) into ALUOut.
            S_DECODE: begin
                src_a = SRC_A_OLDPC;
                src_b = SRC_B_IMM;
            end
            S_MEMADR: begin
                src_a = SRC_A_RS1;
                src_b = SRC_B_IMM;
            end
            S_MEMREAD: begin
                mem_read  = 1'b1;
                adr_src_o = 1'b1;
            end
            S_MEMWRITE: begin
                mem_write = 1'b1;
                adr_src_o = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                result_src = RES_MEMDATA;
            end
            S_EXECR: begin
                src_a  = SRC_A_RS1;
                src_b  = SRC_B_RS2;
                alu_op = ALUOP_FUNCT;
            end
            S_EXECI: begin
                src_a  = SRC_A_RS1;
                src_b  = SRC_B_IMM;
                alu_op = ALUOP_FUNCT;
            end
            S_LUI: begin
                src_a = SRC_A_ZERO;
                src_b = SRC_B_IMM;
            end
            S_AUIPC: begin
                src_a = SRC_A_OLDPC;
                src_b = SRC_B_IMM;
            end
            // PC takes the target from ALUOut while the ALU forms old PC + 4
            // for the link write in ALUWB.
            S_JAL: begin
                pc_write   = 1'b1;
                src_a      = SRC_A_OLDPC;
                src_b      = SRC_B_FOUR;
                result_src = RES_ALUOUT;
            end
            S_JALR: begin
                pc_write   = 1'b1;
                src_a      = SRC_A_RS1;
                src_b      = SRC_B_IMM;
                result_src = RES_ALURESULT;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                result_src = RES_ALUOUT;
            end
            S_BRANCH: begin
                src_a      = SRC_A_RS1;
                src_b      = SRC_B_RS2;
                alu_op     = ALUOP_SUB;
                result_src = RES_ALUOUT;
                pc_write   = branch_taken(funct3, zero_i, lt_i, ltu_i);
            end
            default: ;
        endcase
    end

    always_comb begin
        imm_src_o = IMM_I;
        case (opcode)
            OP_STORE:  imm_src_o = IMM_S;
            OP_BRANCH: imm_src_o = IMM_B;
            OP_LUI,
            OP_AUIPC:  imm_src_o = IMM_U;
            OP_JAL:    imm_src_o = IMM_J;
            default:   imm_src_o = IMM_I;
        endcase
    end

    alu_ctrl_e alu_ctrl;

    alu_decoder u_alu_decoder (
        .alu_op_i   (alu_op),
        .funct3_i   (funct3),
        .funct7b5_i (funct7b5),
        .is_rtype_i (opcode == OP_OP),
        .alu_ctrl_o (alu_ctrl)
    );

    // Reset forces FETCH, which would otherwise request a read; the enables
    // are gated so nothing fires while rst_n is low, even mid-instruction.
    assign pc_write_o   = rst_n & pc_write;
    assign ir_write_o   = rst_n & ir_write;
    assign reg_write_o  = rst_n & reg_write;
    assign mem_read_o   = rst_n & mem_read;
    assign mem_write_o  = rst_n & mem_write;
    assign alu_src_a_o  = src_a;
    assign alu_src_b_o  = src_b;
    assign result_src_o = result_src;
    assign alu_ctrl_o   = alu_ctrl;
    assign illegal_o    = illegal_q;
    assign timeout_o    = timeout_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_control_unit_fsm.sv
// ---------------------------------------------------------------------------
// tb_control_unit_fsm
// Self-checking bench: a table of per-cycle vectors for whole instructions,
// then hand-written sequences for timeout, illegal opcode and reset corners.
// ---------------------------------------------------------------------------
module tb_control_unit_fsm;
    import riscv_ctrl_pkg::*;

    localparam logic [31:0] I_ADDI     = 32'h00500093;
    localparam logic [31:0] I_ADDI_B30 = 32'h40000093;
    localparam logic [31:0] I_SUB      = 32'h402080B3;
    localparam logic [31:0] I_LW       = 32'h0000A103;
    localparam logic [31:0] I_SW       = 32'h0020A023;
    localparam logic [31:0] I_BNE      = 32'h00209463;
    localparam logic [31:0] I_BLTU     = 32'h0020E463;
    localparam logic [31:0] I_JAL      = 32'h008000EF;
    localparam logic [31:0] I_ILL      = 32'h0000007F;

    // Enable vector order: {pc_write, ir_write, reg_write, mem_read, mem_write}
    localparam logic [4:0] E_NONE  = 5'b00000;
    localparam logic [4:0] E_FETCH = 5'b11010;
    localparam logic [4:0] E_RD    = 5'b00010;
    localparam logic [4:0] E_REG   = 5'b00100;
    localparam logic [4:0] E_WR    = 5'b00001;
    localparam logic [4:0] E_PC    = 5'b10000;

    localparam logic [2:0] A_ADD = 3'b000;
    localparam logic [2:0] A_SUB = 3'b001;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        mem_ready;
    logic        zero, lt, ltu;

    logic        pc_w, ir_w, reg_w, mem_rd, mem_wr, adr_src;
    logic [1:0]  src_a, src_b, res_src;
    logic [2:0]  imm_src, alu_ctrl;
    logic        illegal, timeout;
    logic [3:0]  state;

    logic        pc_w2, ir_w2, reg_w2, mem_rd2, mem_wr2, adr_src2;
    logic [1:0]  src_a2, src_b2, res_src2;
    logic [2:0]  imm_src2, alu_ctrl2;
    logic        illegal2, timeout2;
    logic [3:0]  state2;

    logic [4:0]  en, en2;
    assign en  = {pc_w, ir_w, reg_w, mem_rd, mem_wr};
    assign en2 = {pc_w2, ir_w2, reg_w2, mem_rd2, mem_wr2};

    control_unit_fsm #(.MEM_TIMEOUT(16), .TRAP_ILLEGAL(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .instr_i(instr), .mem_ready_i(mem_ready),
        .zero_i(zero), .lt_i(lt), .ltu_i(ltu),
        .pc_write_o(pc_w), .ir_write_o(ir_w), .reg_write_o(reg_w),
        .mem_read_o(mem_rd), .mem_write_o(mem_wr), .adr_src_o(adr_src),
        .alu_src_a_o(src_a), .alu_src_b_o(src_b), .result_src_o(res_src),
        .imm_src_o(imm_src), .alu_ctrl_o(alu_ctrl),
        .illegal_o(illegal), .timeout_o(timeout), .state_o(state)
    );

    control_unit_fsm #(.MEM_TIMEOUT(16), .TRAP_ILLEGAL(1'b0)) u_dut_nt (
        .clk(clk), .rst_n(rst_n), .instr_i(instr), .mem_ready_i(mem_ready),
        .zero_i(zero), .lt_i(lt), .ltu_i(ltu),
        .pc_write_o(pc_w2), .ir_write_o(ir_w2), .reg_write_o(reg_w2),
        .mem_read_o(mem_rd2), .mem_write_o(mem_wr2), .adr_src_o(adr_src2),
        .alu_src_a_o(src_a2), .alu_src_b_o(src_b2), .result_src_o(res_src2),
        .imm_src_o(imm_src2), .alu_ctrl_o(alu_ctrl2),
        .illegal_o(illegal2), .timeout_o(timeout2), .state_o(state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock, then settle just past the edge before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst_n;
        logic [31:0] instr;
        logic        ready;
        logic [2:0]  flags;   // {zero, lt, ltu}
        state_e      st;
        logic [4:0]  en;
        logic [2:0]  alu;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic r, input logic [31:0] i, input logic rdy,
                               input logic [2:0] f, input state_e s,
                               input logic [4:0] e, input logic [2:0] a);
        vec_t x;
        x.rst_n = r; x.instr = i; x.ready = rdy; x.flags = f;
        x.st = s; x.en = e; x.alu = a;
        return x;
    endfunction

    initial begin
        rst_n = 1'b0; instr = I_ADDI; mem_ready = 1'b1;
        zero = 1'b0; lt = 1'b0; ltu = 1'b0;

        // Reset: FETCH but no enables
        vecs.push_back(v(0, I_ADDI, 1, 3'b000, S_FETCH,  E_NONE,  A_ADD));
        // ADDI, ready immediately: 4 cycles, reg_write only in ALUWB
        vecs.push_back(v(1, I_ADDI, 1, 3'b000, S_FETCH,  E_FETCH, A_ADD));
        vecs.push_back(v(1, I_ADDI, 1, 3'b000, S_DECODE, E_NONE,  A_ADD));
        vecs.push_back(v(1, I_ADDI, 1, 3'b000, S_EXECI,  E_NONE,  A_ADD));
        vecs.push_back(v(1, I_ADDI, 1, 3'b000, S_ALUWB,  E_REG,   A_ADD));
        // ADDI with bit 30 set after a one-cycle fetch wait: still ADD
        vecs.push_back(v(1, I_ADDI_B30, 0, 3'b000, S_FETCH,  E_RD,    A_ADD));
        vecs.push_back(v(1, I_ADDI_B30, 1, 3'b000, S_FETCH,  E_FETCH, A_ADD));
        vecs.push_back(v(1, I_ADDI_B30, 1, 3'b000, S_DECODE, E_NONE,  A_ADD));
        vecs.push_back(v(1, I_ADDI_B30, 1, 3'b000, S_EXECI,  E_NONE,  A_ADD));
        vecs.push_back(v(1, I_ADDI_B30, 1, 3'b000, S_ALUWB,  E_REG,   A_ADD));
        // SUB: EXECR selects SUB, ALUWB back to ADD
        vecs.push_back(v(1, I_SUB, 1, 3'b000, S_FETCH,  E_FETCH, A_ADD));
        vecs.push_back(v(1, I_SUB, 1, 3'b000, S_DECODE, E_NONE,  A_ADD));
        vecs.push_back(v(1, I_SUB, 1, 3'b000, S_EXECR,  E_NONE,  A_SUB));
        vecs.push_back(v(1, I_SUB, 1, 3'b000, S_ALUWB,  E_REG,   A_ADD));
        // LW with ready 3 cycles late: mem_read held 4 cycles in MEMREAD
        vecs.push_back(v(1, I_LW, 1, 3'b000, S_FETCH,   E_FETCH, A_ADD));
        vecs.push_back(v(1, I_LW, 1, 3'b000, S_DECODE,  E_NONE,  A_ADD));
        vecs.push_back(v(1, I_LW, 1, 3'b000, S_MEMADR,  E_NONE,  A_ADD));
        vecs.push_back(v(1, I_LW, 0, 3'b000, S_MEMREAD, E_RD,    A_ADD));
        vecs.push_back(v(1, I_LW, 0, 3'b000, S_MEMREAD, E_RD,    A_ADD));
        vecs.push_back(v(1, I_LW, 0, 3'b000, S_MEMREAD, E_RD,    A_ADD));
        vecs.push_back(v(1, I_LW, 1, 3'b000, S_MEMREAD, E_RD,    A_ADD));
        vecs.push_back(v(1, I_LW, 1, 3'b000, S_MEMWB,   E_REG,   A_ADD));
        // SW with one wait cycle
        vecs.push_back(v(1, I_SW, 1, 3'b000, S_FETCH,    E_FETCH, A_ADD));
        vecs.push_back(v(1, I_SW, 1, 3'b000, S_DECODE,   E_NONE,  A_ADD));
        vecs.push_back(v(1, I_SW, 1, 3'b000, S_MEMADR,   E_NONE,  A_ADD));
        vecs.push_back(v(1, I_SW, 0, 3'b000, S_MEMWRITE, E_WR,    A_ADD));
        vecs.push_back(v(1, I_SW, 1, 3'b000, S_MEMWRITE, E_WR,    A_ADD));
        // BNE taken (zero=0) and not taken (zero=1)
        vecs.push_back(v(1, I_BNE, 1, 3'b000, S_FETCH,  E_FETCH, A_ADD));
        vecs.push_back(v(1, I_BNE, 1, 3'b000, S_DECODE, E_NONE,  A_ADD));
        vecs.push_back(v(1, I_BNE, 1, 3'b000, S_BRANCH, E_PC,    A_SUB));
        vecs.push_back(v(1, I_BNE, 1, 3'b100, S_FETCH,  E_FETCH, A_ADD));
        vecs.push_back(v(1, I_BNE, 1, 3'b100, S_DECODE, E_NONE,  A_ADD));
        vecs.push_back(v(1, I_BNE, 1, 3'b100, S_BRANCH, E_NONE,  A_SUB));
        // BLTU taken on ltu=1
        vecs.push_back(v(1, I_BLTU, 1, 3'b001, S_FETCH,  E_FETCH, A_ADD));
        vecs.push_back(v(1, I_BLTU, 1, 3'b001, S_DECODE, E_NONE,  A_ADD));
        vecs.push_back(v(1, I_BLTU, 1, 3'b001, S_BRANCH, E_PC,    A_SUB));
        // JAL: PC write in JAL, link write in ALUWB
        vecs.push_back(v(1, I_JAL, 1, 3'b000, S_FETCH,  E_FETCH, A_ADD));
        vecs.push_back(v(1, I_JAL, 1, 3'b000, S_DECODE, E_NONE,  A_ADD));
        vecs.push_back(v(1, I_JAL, 1, 3'b000, S_JAL,    E_PC,    A_ADD));
        vecs.push_back(v(1, I_JAL, 1, 3'b000, S_ALUWB,  E_REG,   A_ADD));
        vecs.push_back(v(1, I_JAL, 1, 3'b000, S_FETCH,  E_FETCH, A_ADD));

        foreach (vecs[k]) begin
            rst_n = vecs[k].rst_n; instr = vecs[k].instr; mem_ready = vecs[k].ready;
            {zero, lt, ltu} = vecs[k].flags;
            #1;
            check($sformatf("vec%0d state", k), 32'(state),    32'(vecs[k].st));
            check($sformatf("vec%0d en", k),    32'(en),       32'(vecs[k].en));
            check($sformatf("vec%0d alu", k),   32'(alu_ctrl), 32'(vecs[k].alu));
            @(posedge clk);
            #1;
        end
        // Last vector was FETCH with ready: now in DECODE of a JAL; finish it.
        tick(); tick(); tick();
        check("post-table state", 32'(state), 32'(S_FETCH));

        // Ready arriving on wait cycle 16 still wins.
        instr = I_ADDI; mem_ready = 1'b0; {zero, lt, ltu} = 3'b000;
        for (int c = 1; c <= 15; c++) tick();
        check("late16 still fetch", 32'(state), 32'(S_FETCH));
        mem_ready = 1'b1;
        #1;
        check("late16 pc_write", 32'(pc_w), 32'(1));
        tick();
        check("late16 decode", 32'(state), 32'(S_DECODE));
        check("late16 no timeout", 32'(timeout), 32'(0));
        tick(); tick(); tick();
        check("late16 back to fetch", 32'(state), 32'(S_FETCH));

        // Full timeout: 16 wait cycles in FETCH.
        mem_ready = 1'b0;
        for (int c = 1; c <= 15; c++) tick();
        check("timeout c15 fetch", 32'(state), 32'(S_FETCH));
        check("timeout c15 flag", 32'(timeout), 32'(0));
        tick();
        check("timeout state", 32'(state), 32'(S_ERROR));
        check("timeout flag", 32'(timeout), 32'(1));
        mem_ready = 1'b1; zero = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("error absorbing", 32'(state), 32'(S_ERROR));
            check("error enables", 32'(en), 32'(E_NONE));
            check("error flag sticky", 32'(timeout), 32'(1));
        end
        // Reset pulse away from any edge clears the flags.
        mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst clears state", 32'(state), 32'(S_FETCH));
        check("rst clears timeout", 32'(timeout), 32'(0));
        check("rst gates enables", 32'(en), 32'(E_NONE));
        rst_n = 1'b1;
        #1;
        check("after rst mem_read", 32'(en), 32'(E_RD));
        tick();

        // Illegal opcode: trap vs NOP variants share the stimulus.
        instr = I_ILL; mem_ready = 1'b1;
        tick();
        check("ill decode", 32'(state), 32'(S_DECODE));
        check("ill decode nt", 32'(state2), 32'(S_DECODE));
        check("ill decode nt en", 32'(en2), 32'(E_NONE));
        tick();
        check("ill trap state", 32'(state), 32'(S_ERROR));
        check("ill trap flag", 32'(illegal), 32'(1));
        check("ill nop state", 32'(state2), 32'(S_FETCH));
        check("ill nop flag", 32'(illegal2), 32'(0));
        mem_ready = 1'b0;
        #1;
        check("ill trap en", 32'(en), 32'(E_NONE));
        check("ill nop en", 32'(en2), 32'(E_RD));
        rst_n = 1'b0;
        #1;
        check("ill rst state", 32'(state), 32'(S_FETCH));
        check("ill rst flag", 32'(illegal), 32'(0));
        tick();
        rst_n = 1'b1;

        // Reset asserted mid-load while mem_read is active.
        instr = I_LW; mem_ready = 1'b1;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        #1;
        check("mid ld memread", 32'(state), 32'(S_MEMREAD));
        check("mid ld en", 32'(en), 32'(E_RD));
        #2 rst_n = 1'b0;
        #1;
        check("mid rst state", 32'(state), 32'(S_FETCH));
        check("mid rst en", 32'(en), 32'(E_NONE));
        tick();
        check("mid rst hold en", 32'(en), 32'(E_NONE));
        rst_n = 1'b1;
        #1;
        check("mid rst release", 32'(en), 32'(E_RD));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
